wb_port_arbiter: RTL and testbench
==================================

WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 The block SHALL have exactly one clock domain, and its reset SHALL be asynchronous and active-high.
REQ-002 The block SHALL have port clk, input, 1 bit: the rising-edge clock for all state.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous active-high reset.
REQ-004 The block SHALL have port wb_valid, input, 1 bit: the pipeline writeback stage requests a register-file write this cycle.
REQ-005 The block SHALL have port wb_reg, input, 3 bits: the pipeline destination register.
REQ-006 The block SHALL have port wb_data, input, 16 bits: the pipeline write data.
REQ-007 The block SHALL have port ld_valid, input, 1 bit: the multi-cycle memory returns late load data this cycle.
REQ-008 The block SHALL have port ld_reg, input, 3 bits: the late-load destination register.
REQ-009 The block SHALL have port ld_data, input, 16 bits: the late-load data.
REQ-010 The block SHALL have port ld_ready, output, 1 bit: the block can accept a late load this cycle.
REQ-011 The block SHALL have port rf_we, output, 1 bit: the registered register-file write enable.
REQ-012 The block SHALL have port rf_wreg, output, 3 bits: the registered write register.
REQ-013 The block SHALL have port rf_wdata, output, 16 bits: the registered write data.
REQ-014 The block SHALL have port pending_mask, output, 8 bits: bit n is 1 while a queued late-load write targets register n.
REQ-015 The block SHALL have port ovf_err, output, 1 bit: sticky flag, set when ld_valid arrives while ld_ready is 0.

Function
REQ-016 The block SHALL hold a 2-entry in-order queue; each entry is {valid, reg[2:0], data[15:0]}.
REQ-017 The queue state SHALL be EMPTY, ONE or FULL, set by the count of valid entries.
REQ-018 ld_ready SHALL be 1 in EMPTY and ONE and 0 in FULL, decoded from registered state only.
REQ-019 A load SHALL be accepted only when ld_valid is 1 and ld_ready is 1.
REQ-020 Port selection SHALL use this priority each cycle: (1) wb_valid, (2) queue head, (3) a direct write of the accepted load.
REQ-021 When wb_valid is 1, the block SHALL write {wb_reg, wb_data} and SHALL enqueue any accepted load at the tail.
REQ-022 When wb_valid is 0 and the queue is not EMPTY, the block SHALL write and pop the head; an accepted load SHALL be enqueued in the same cycle, with pop before push, so ONE stays ONE.
REQ-023 When wb_valid is 0 and the queue is EMPTY, an accepted load SHALL be written directly and SHALL NOT be enqueued.
REQ-024 When no write source exists, rf_we SHALL be 0 on the next edge; rf_wreg and rf_wdata SHALL hold their previous values.
REQ-025 Latency SHALL be exactly 1 cycle: the selected source appears on rf_* after the next rising edge.
REQ-026 Kill rule: when wb_valid is 1, every queued entry with reg equal to wb_reg SHALL be invalidated on the same edge, because the pipeline write is younger.
REQ-027 Under the kill rule, an accepted load with ld_reg equal to wb_reg in the same cycle SHALL be consumed and discarded, not enqueued.
REQ-028 Compaction: if the head is killed and the tail survives, the tail SHALL move to the head on the same edge.
REQ-029 Kill and enqueue in the same cycle SHALL give count = survivors + new entry; the new entry SHALL be placed behind the survivors.
REQ-030 A load with ld_valid=1 and ld_ready=0 SHALL be dropped, SHALL set ovf_err, and SHALL NOT change queue contents.
REQ-031 pending_mask SHALL be the combinational OR of one-hot(reg) over valid queue entries.
REQ-032 pending_mask SHALL NOT reflect a load in its acceptance cycle.
REQ-033 Two valid entries MAY target the same register; both SHALL be written in order.

Reset
REQ-034 While rst is 1, the block SHALL force: queue EMPTY with all valid bits 0, rf_we=0, rf_wreg=0, rf_wdata=0, ovf_err=0, ld_ready=1, pending_mask=0.
REQ-035 A reset asserted mid-drain SHALL discard queued entries, and no write of them SHALL occur after reset.
REQ-036 Only rst SHALL clear ovf_err.

Verification
REQ-037 Bench SHALL cover direct load: EMPTY, ld_valid=1 with ld_reg=3 and ld_data=0x1234, wb_valid=0 -> next cycle rf_we=1, rf_wreg=3, rf_wdata=0x1234, pending_mask=0.
REQ-038 Bench SHALL cover conflict: wb_valid=1 (reg 1, 0xAAAA) with load (reg 2, 0xBBBB) -> cycle+1 writes reg 1 and pending_mask=0x04; cycle+2 writes reg 2, 0xBBBB and pending_mask=0x00.
REQ-039 Bench SHALL cover full: three back-to-back loads (regs 4, 5, 6) under continuous wb_valid -> ld_ready=0 after 2 loads; third load dropped and ovf_err=1; queue drains reg 4 then reg 5 once wb_valid=0.
REQ-040 Bench SHALL cover kill: queue holds {reg 5, reg 6}, then wb_valid=1 to reg 5 -> next cycle head is reg 6, count=1, pending_mask=0x40; reg 5 is never written with the load data.
REQ-041 Bench SHALL cover same-cycle kill: wb_valid=1 to reg 7 and load to reg 7 together -> only the wb data is written, queue stays EMPTY, and ld_ready stays 1.
REQ-042 Bench SHALL cover reset mid-operation: FULL queue, rst pulsed asynchronously between edges -> outputs go to reset values immediately, and no queued write appears afterwards.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: the pipeline writeback wins, and late loads wait in a
// 2-entry in-order queue. A pipeline write kills older queued writes to the same register.
module wb_port_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_valid,
    input  logic [2:0]  wb_reg,
    input  logic [15:0] wb_data,
    input  logic        ld_valid,
    input  logic [2:0]  ld_reg,
    input  logic [15:0] ld_data,
    output logic        ld_ready,
    output logic        rf_we,
    output logic [2:0]  rf_wreg,
    output logic [15:0] rf_wdata,
    output logic [7:0]  pending_mask,
    output logic        ovf_err,
    output logic [1:0]  dbg_state
);

    // Encoded value equals the number of valid queue entries.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } q_state_e;

    q_state_e    state_q, state_d;
    logic [1:0]  vld_q, vld_d;
    logic [2:0]  reg_q  [2];
    logic [2:0]  reg_d  [2];
    logic [15:0] data_q [2];
    logic [15:0] data_d [2];
    logic        rf_we_q, rf_we_d;
    logic [2:0]  rf_wreg_q, rf_wreg_d;
    logic [15:0] rf_wdata_q, rf_wdata_d;
    logic        ovf_q;

    logic        ld_accept;
    logic [1:0]  kill;
    logic [1:0]  surv;
    logic        push;

    assign ld_ready  = (state_q != FULL);
    assign ld_accept = ld_valid & ld_ready;
    assign rf_we     = rf_we_q;
    assign rf_wreg   = rf_wreg_q;
    assign rf_wdata  = rf_wdata_q;
    assign ovf_err   = ovf_q;
    assign dbg_state = state_q;

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            kill[i] = wb_valid & vld_q[i] & (reg_q[i] == wb_reg);
        end
        surv = vld_q & ~kill;
    end

    always_comb begin
        vld_d      = 2'b00;
        reg_d      = reg_q;
        data_d     = data_q;
        rf_we_d    = 1'b0;
        rf_wreg_d  = rf_wreg_q;
        rf_wdata_d = rf_wdata_q;
        push       = 1'b0;
        state_d    = EMPTY;

        if (wb_valid) begin
            rf_we_d    = 1'b1;
            rf_wreg_d  = wb_reg;
            rf_wdata_d = wb_data;
            if (surv[0]) begin
                vld_d = surv;
            end else if (surv[1]) begin
                vld_d[0]  = 1'b1;
                reg_d[0]  = reg_q[1];
                data_d[0] = data_q[1];
            end
            // A same-register load is older than the pipeline write, so it is consumed and dropped.
            push = ld_accept & (ld_reg != wb_reg);
        end else if (vld_q[0]) begin
            rf_we_d    = 1'b1;
            rf_wreg_d  = reg_q[0];
            rf_wdata_d = data_q[0];
            if (vld_q[1]) begin
                vld_d[0]  = 1'b1;
                reg_d[0]  = reg_q[1];
                data_d[0] = data_q[1];
            end
            push = ld_accept;
        end else if (ld_accept) begin
            rf_we_d    = 1'b1;
            rf_wreg_d  = ld_reg;
            rf_wdata_d = ld_data;
        end

        if (push) begin
            if (!vld_d[0]) begin
                vld_d[0]  = 1'b1;
                reg_d[0]  = ld_reg;
                data_d[0] = ld_data;
            end else begin
                vld_d[1]  = 1'b1;
                reg_d[1]  = ld_reg;
                data_d[1] = ld_data;
            end
        end

        case (vld_d)
            2'b01:   state_d = ONE;
            2'b11:   state_d = FULL;
            default: state_d = EMPTY;
        endcase
    end

    always_comb begin
        pending_mask = 8'h00;
        for (int i = 0; i < 2; i++) begin
            if (vld_q[i]) pending_mask[reg_q[i]] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= EMPTY;
            vld_q      <= 2'b00;
            reg_q[0]   <= 3'd0;
            reg_q[1]   <= 3'd0;
            data_q[0]  <= 16'h0000;
            data_q[1]  <= 16'h0000;
            rf_we_q    <= 1'b0;
            rf_wreg_q  <= 3'd0;
            rf_wdata_q <= 16'h0000;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            vld_q      <= vld_d;
            reg_q      <= reg_d;
            data_q     <= data_d;
            rf_we_q    <= rf_we_d;
            rf_wreg_q  <= rf_wreg_d;
            rf_wdata_q <= rf_wdata_d;
            ovf_q      <= ovf_q | (ld_valid & ~ld_ready);
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed scenarios with literal expectations, then random
// traffic, all compared each cycle against a queue-based model of the write-port rules.
module tb_wb_port_arbiter;

    logic        clk;
    logic        rst;
    logic        wb_valid;
    logic [2:0]  wb_reg;
    logic [15:0] wb_data;
    logic        ld_valid;
    logic [2:0]  ld_reg;
    logic [15:0] ld_data;
    logic        ld_ready;
    logic        rf_we;
    logic [2:0]  rf_wreg;
    logic [15:0] rf_wdata;
    logic [7:0]  pending_mask;
    logic        ovf_err;
    logic [1:0]  dbg_state;

    int n_cmp = 0;
    int n_bad = 0;

    wb_port_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .wb_valid     (wb_valid),
        .wb_reg       (wb_reg),
        .wb_data      (wb_data),
        .ld_valid     (ld_valid),
        .ld_reg       (ld_reg),
        .ld_data      (ld_data),
        .ld_ready     (ld_ready),
        .rf_we        (rf_we),
        .rf_wreg      (rf_wreg),
        .rf_wdata     (rf_wdata),
        .pending_mask (pending_mask),
        .ovf_err      (ovf_err),
        .dbg_state    (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model: queue entries are {reg[2:0], data[15:0]}
    logic [18:0] exp_q[$];
    logic        m_we;
    logic [2:0]  m_reg;
    logic [15:0] m_data;
    logic        m_ovf;

    always @(posedge clk or posedge rst) begin : model
        logic        acc;
        logic [18:0] kept[$];
        logic [18:0] head;
        if (rst) begin
            exp_q.delete();
            m_we   = 1'b0;
            m_reg  = 3'd0;
            m_data = 16'h0000;
            m_ovf  = 1'b0;
        end else begin
            acc = ld_valid && (exp_q.size() < 2);
            if (ld_valid && !acc) m_ovf = 1'b1;
            if (wb_valid) begin
                m_we   = 1'b1;
                m_reg  = wb_reg;
                m_data = wb_data;
                kept.delete();
                foreach (exp_q[i]) if (exp_q[i][18:16] != wb_reg) kept.push_back(exp_q[i]);
                exp_q = kept;
                if (acc && ld_reg != wb_reg) exp_q.push_back({ld_reg, ld_data});
            end else if (exp_q.size() > 0) begin
                head   = exp_q.pop_front();
                m_we   = 1'b1;
                m_reg  = head[18:16];
                m_data = head[15:0];
                if (acc) exp_q.push_back({ld_reg, ld_data});
            end else if (acc) begin
                m_we   = 1'b1;
                m_reg  = ld_reg;
                m_data = ld_data;
            end else begin
                m_we = 1'b0;
            end
        end
    end

    function automatic logic [7:0] model_mask();
        logic [7:0] m = 8'h00;
        foreach (exp_q[i]) m[exp_q[i][18:16]] = 1'b1;
        return m;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // scoreboard compare, every cycle outside reset
    always @(negedge clk) begin
        if (!rst) begin
            chk("rf_we", 32'(rf_we), 32'(m_we));
            chk("rf_wreg", 32'(rf_wreg), 32'(m_reg));
            chk("rf_wdata", 32'(rf_wdata), 32'(m_data));
            chk("ld_ready", 32'(ld_ready), 32'(exp_q.size() < 2));
            chk("pending_mask", 32'(pending_mask), 32'(model_mask()));
            chk("ovf_err", 32'(ovf_err), 32'(m_ovf));
            chk("state", 32'(dbg_state), 32'(exp_q.size()));
        end
    end

    // driver tasks (called at a negedge; return at the next negedge)
    task automatic idle();
        wb_valid = 1'b0; wb_reg = 3'd0; wb_data = 16'h0000;
        ld_valid = 1'b0; ld_reg = 3'd0; ld_data = 16'h0000;
    endtask

    task automatic drive(input logic wv, input logic [2:0] wr, input logic [15:0] wd,
                         input logic lv, input logic [2:0] lr, input logic [15:0] ld);
        wb_valid = wv; wb_reg = wr; wb_data = wd;
        ld_valid = lv; ld_reg = lr; ld_data = ld;
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic chk_write(input string name, input logic [2:0] r, input logic [15:0] d);
        chk({name, "_we"}, 32'(rf_we), 32'd1);
        chk({name, "_reg"}, 32'(rf_wreg), 32'(r));
        chk({name, "_data"}, 32'(rf_wdata), 32'(d));
    endtask

    initial begin
        rst = 1'b1;
        idle();
        repeat (2) cyc();
        chk("rst_we", 32'(rf_we), 32'd0);
        chk("rst_ready", 32'(ld_ready), 32'd1);
        chk("rst_mask", 32'(pending_mask), 32'd0);
        chk("rst_ovf", 32'(ovf_err), 32'd0);
        rst = 1'b0;
        cyc();

        // direct load into empty queue
        drive(0, 0, 0, 1, 3'd3, 16'h1234);
        cyc(); idle();
        chk_write("direct", 3'd3, 16'h1234);
        chk("direct_mask", 32'(pending_mask), 32'h00);

        // pipeline write and load in the same cycle
        drive(1, 3'd1, 16'hAAAA, 1, 3'd2, 16'hBBBB);
        cyc(); idle();
        chk_write("conf1", 3'd1, 16'hAAAA);
        chk("conf1_mask", 32'(pending_mask), 32'h04);
        cyc();
        chk_write("conf2", 3'd2, 16'hBBBB);
        chk("conf2_mask", 32'(pending_mask), 32'h00);
        cyc();

        // fill to FULL, overflow, then drain
        drive(1, 3'd0, 16'h0101, 1, 3'd4, 16'h4444);
        cyc();
        chk("full1_ready", 32'(ld_ready), 32'd1);
        drive(1, 3'd0, 16'h0202, 1, 3'd5, 16'h5555);
        cyc();
        chk("full2_ready", 32'(ld_ready), 32'd0);
        chk("full2_mask", 32'(pending_mask), 32'h30);
        drive(1, 3'd0, 16'h0303, 1, 3'd6, 16'h6666);
        cyc(); idle();
        chk("full3_ovf", 32'(ovf_err), 32'd1);
        chk("full3_mask", 32'(pending_mask), 32'h30);
        cyc();
        chk_write("drain1", 3'd4, 16'h4444);
        cyc();
        chk_write("drain2", 3'd5, 16'h5555);
        cyc();
        chk("drain3_we", 32'(rf_we), 32'd0);

        // kill of the queue head with compaction
        drive(1, 3'd0, 16'h0000, 1, 3'd5, 16'h5005);
        cyc();
        drive(1, 3'd0, 16'h0000, 1, 3'd6, 16'h6006);
        cyc();
        drive(1, 3'd5, 16'h0F0F, 0, 3'd0, 16'h0000);
        cyc(); idle();
        chk_write("kill", 3'd5, 16'h0F0F);
        chk("kill_mask", 32'(pending_mask), 32'h40);
        chk("kill_state", 32'(dbg_state), 32'd1);
        cyc();
        chk_write("kill_drain", 3'd6, 16'h6006);
        cyc();
        chk("kill_idle_we", 32'(rf_we), 32'd0);

        // same-cycle kill of the incoming load
        drive(1, 3'd7, 16'h7777, 1, 3'd7, 16'h1111);
        cyc(); idle();
        chk_write("skill", 3'd7, 16'h7777);
        chk("skill_mask", 32'(pending_mask), 32'h00);
        chk("skill_ready", 32'(ld_ready), 32'd1);
        cyc();
        chk("skill_idle_we", 32'(rf_we), 32'd0);

        // asynchronous reset with a FULL queue
        drive(1, 3'd0, 16'h0001, 1, 3'd1, 16'h1010);
        cyc();
        drive(1, 3'd0, 16'h0002, 1, 3'd2, 16'h2020);
        cyc(); idle();
        #2 rst = 1'b1;
        #1;
        chk("arst_we", 32'(rf_we), 32'd0);
        chk("arst_reg", 32'(rf_wreg), 32'd0);
        chk("arst_data", 32'(rf_wdata), 32'd0);
        chk("arst_mask", 32'(pending_mask), 32'h00);
        chk("arst_ready", 32'(ld_ready), 32'd1);
        chk("arst_ovf", 32'(ovf_err), 32'd0);
        cyc();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("arst_after_we", 32'(rf_we), 32'd0);
        end

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 99) < 40, 3'($urandom_range(0, 7)), 16'($urandom),
                  $urandom_range(0, 99) < 60, 3'($urandom_range(0, 7)), 16'($urandom));
            cyc();
        end
        idle();
        repeat (3) cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
